prio_arbiter_rr: RTL and testbench
==================================

// Module: prio_arbiter_rr
// PURPOSE
//  Registered N-way request arbiter; parametrised successor to the 4:2 combinational priority encoder.
//  Accepts N request lines and issues one registered grant (one-hot plus binary index).
//  Two runtime modes: fixed priority (highest index wins) or round-robin.
//  Grant is held while the winner keeps requesting; optional hold limit forces fairness.
//  Sits in front of shared resources (bus, memory port) that multiple requesters contend for.
// PARAMETERS
//  N        4  number of requesters, 2..32
//  IDX_W    2  width of gnt_idx; must equal clog2(N)
//  MAX_HOLD 0  max consecutive grant cycles while others wait; 0 = unlimited
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  rst        in   1      asynchronous reset, active-high
//  req        in   N      request vector; req[i]=1 means requester i wants the resource
//  rr_en      in   1      0 = fixed priority (highest index wins); 1 = round-robin
//  gnt        out  N      one-hot grant, registered; all zero when nothing is granted
//  gnt_idx    out  IDX_W  binary index of the granted requester; valid only when gnt_valid=1
//  gnt_valid  out  1      1 while any grant is active
// BEHAVIOUR
//  Reset: gnt=0, gnt_idx=0, gnt_valid=0, state=IDLE, rr pointer ptr=0, hold count cnt=0.
//   Reset asserted mid-grant clears the grant immediately (asynchronous).
//  Latency: 1 clock. req sampled at edge t produces gnt at edge t.
//   Visible after edge t; no combinational req->gnt path.
//  States:
//   IDLE.   Entered when no grant is active.
//    If req!=0: arbitrate, move to GRANT.
//   GRANT.  Holds the current winner w while req[w]=1.
//    If req[w]=0 and other requests are pending: arbitrate among req and switch to the new winner at the same edge.
//     There is no idle bubble between grants.
//    If req[w]=0 and req==0: go to IDLE, gnt=0, gnt_valid=0.
//  Arbitration, given candidate vector c:
//   rr_en=0: winner = highest set index of c.
//   rr_en=1: scan ptr, ptr+1, ..., N-1, 0, ..., ptr-1; the first set bit wins.
//  Pointer and mode:
//   On every new grant, ptr <= (winner+1) mod N in both modes.
//   rr_en is sampled only at arbitration edges; toggling it never disturbs a held grant.
//  Hold limit (MAX_HOLD>0):
//   cnt is set to 1 at each new grant and increments each cycle the grant is held; it saturates at MAX_HOLD.
//   When cnt==MAX_HOLD, req[w]=1 and (req & ~gnt)!=0: re-arbitrate with c = req & ~gnt (w masked for that decision).
//    The new winner is granted at that edge.
//   If w is the only requester, the grant is kept and cnt stays saturated.
//  Width rules: gnt is always zero or one-hot. gnt_idx is unchanged while gnt_valid=0.
//   A switch updates gnt, gnt_idx and gnt_valid together at the same edge.
//  req bits for i>=N do not exist; no X propagation. Unknown/illegal states recover to IDLE.
// TESTING (N=4 unless noted)
//  1. Reset, then rr_en=0, req=0000 -> gnt=0000, gnt_valid=0.
//     req=1010 -> next edge gnt=1000, gnt_idx=3.
//  2. Fixed mode, req=0110 held -> gnt=0100 stays.
//     Drop req[2] (req=0010) -> same edge gnt=0010, gnt_idx=1, no gnt=0 cycle.
//  3. rr_en=1, req=1111 held; each winner drops req for one cycle after 1 grant.
//     -> grant order 0,1,2,3,0 (from ptr=0).
//  4. MAX_HOLD=3, rr_en=0, req=1001 held -> gnt=1000 for 3 cycles, then 0001.
//     Next edge after 3 cycles of 0001: gnt=1000 again.
//  5. MAX_HOLD=3, req=0100 only, held 10 cycles -> gnt=0100 throughout, gnt_valid=1.
//  6. Assert rst mid-grant (gnt=0010) -> gnt=0000, gnt_valid=0, gnt_idx=0 without waiting for a clock edge.
//     After release with rr_en=1, req=1111 -> gnt=0001.

Source files
------------

// File: rtl/prio_arbiter_rr.sv
// Registered N-way request arbiter: fixed-priority or round-robin selection,
// grant held while the winner keeps requesting, optional hold limit for fairness.
module prio_arbiter_rr #(
    parameter int N        = 4,
    parameter int IDX_W    = 2,
    parameter int MAX_HOLD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             rr_en,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;

    localparam int CNT_MAX = (MAX_HOLD > 0) ? MAX_HOLD : 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [1:0]       state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [N-1:0]     cand;
    logic [IDX_W-1:0] fp_idx;
    logic [IDX_W-1:0] rr_idx;
    logic [IDX_W-1:0] win_idx;
    logic             held;
    logic             pending;
    logic             hold_up;
    logic             take;
    int               rr_best;
    int               rr_dist;

    // The current winner is masked out, so one vector serves both a fresh
    // pick after a drop and the forced hand-over when the hold limit hits.
    assign cand    = req & ~gnt_q;
    assign held    = |(req & gnt_q);
    assign pending = |cand;
    assign hold_up = (MAX_HOLD != 0) && (cnt_q == CNT_W'(CNT_MAX));

    always_comb begin : fixed_pick
        fp_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (cand[i]) begin
                fp_idx = IDX_W'(i);
            end
        end
    end

    // Round-robin: the candidate with the smallest forward distance from ptr.
    always_comb begin : rr_pick
        rr_idx  = '0;
        rr_best = N;
        rr_dist = 0;
        for (int i = 0; i < N; i++) begin
            rr_dist = i - int'(ptr_q);
            if (rr_dist < 0) begin
                rr_dist = rr_dist + N;
            end
            if (cand[i] && (rr_dist < rr_best)) begin
                rr_best = rr_dist;
                rr_idx  = IDX_W'(i);
            end
        end
    end

    assign win_idx = rr_en ? rr_idx : fp_idx;

    always_comb begin : next_state
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        take    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pending) begin
                    take = 1'b1;
                end
            end
            S_GRANT: begin
                if (held) begin
                    if (hold_up && pending) begin
                        take = 1'b1;
                    end else if (cnt_q != CNT_W'(CNT_MAX)) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (pending) begin
                    take = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase

        if (take) begin
            state_d        = S_GRANT;
            gnt_d          = '0;
            gnt_d[win_idx] = 1'b1;
            idx_d          = win_idx;
            cnt_d          = CNT_W'(1);
            if (win_idx == IDX_W'(N - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = win_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = (state_q == S_GRANT);

endmodule

// File: tb/tb_prio_arbiter_rr.sv
// Bench for prio_arbiter_rr: one instance without hold limit, one with
// MAX_HOLD=3; expectations queued at drive time and checked after each edge.
module tb_prio_arbiter_rr;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic [3:0] req_a, req_b;
    logic       rr_a, rr_b;
    logic [3:0] gnt_a, gnt_b;
    logic [1:0] idx_a, idx_b;
    logic       vld_a, vld_b;

    always #5 clk = ~clk;

    prio_arbiter_rr #(.N(4), .IDX_W(2), .MAX_HOLD(0)) u_a (
        .clk       (clk),
        .rst       (rst_a),
        .req       (req_a),
        .rr_en     (rr_a),
        .gnt       (gnt_a),
        .gnt_idx   (idx_a),
        .gnt_valid (vld_a)
    );

    prio_arbiter_rr #(.N(4), .IDX_W(2), .MAX_HOLD(3)) u_b (
        .clk       (clk),
        .rst       (rst_b),
        .req       (req_b),
        .rr_en     (rr_b),
        .gnt       (gnt_b),
        .gnt_idx   (idx_b),
        .gnt_valid (vld_b)
    );

    typedef struct {
        logic [3:0] req;
        logic       rr;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       vld;
    } vec_t;

    typedef struct {
        bit         sel;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       vld;
        int         tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t tbl[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t v(input logic [3:0] r, input logic rr,
                               input logic [3:0] g, input logic [1:0] ix,
                               input logic vl);
        vec_t t;
        t.req = r;
        t.rr  = rr;
        t.gnt = g;
        t.idx = ix;
        t.vld = vl;
        return t;
    endfunction

    task automatic drive(input bit sel, input logic [3:0] r, input logic rr,
                         input logic [3:0] g, input logic [1:0] ix,
                         input logic vl, input int tag);
        exp_t e;
        @(negedge clk);
        if (sel) begin
            req_b = r;
            rr_b  = rr;
        end else begin
            req_a = r;
            rr_a  = rr;
        end
        e.sel = sel;
        e.gnt = g;
        e.idx = ix;
        e.vld = vl;
        e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            if (mon_e.sel) begin
                chk($sformatf("B%0d.gnt", mon_e.tag), 32'(gnt_b), 32'(mon_e.gnt));
                chk($sformatf("B%0d.idx", mon_e.tag), 32'(idx_b), 32'(mon_e.idx));
                chk($sformatf("B%0d.vld", mon_e.tag), 32'(vld_b), 32'(mon_e.vld));
            end else begin
                chk($sformatf("A%0d.gnt", mon_e.tag), 32'(gnt_a), 32'(mon_e.gnt));
                chk($sformatf("A%0d.idx", mon_e.tag), 32'(idx_a), 32'(mon_e.idx));
                chk($sformatf("A%0d.vld", mon_e.tag), 32'(vld_a), 32'(mon_e.vld));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // req, rr_en -> gnt, gnt_idx, gnt_valid (instance without hold limit)
        tbl.push_back(v(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0));
        tbl.push_back(v(4'b1010, 1'b0, 4'b1000, 2'd3, 1'b1));
        tbl.push_back(v(4'b0110, 1'b0, 4'b0100, 2'd2, 1'b1));
        tbl.push_back(v(4'b0110, 1'b0, 4'b0100, 2'd2, 1'b1));
        tbl.push_back(v(4'b0110, 1'b0, 4'b0100, 2'd2, 1'b1));
        tbl.push_back(v(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1));
        tbl.push_back(v(4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0));
        tbl.push_back(v(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1));
        tbl.push_back(v(4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0));
        tbl.push_back(v(4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1));
        tbl.push_back(v(4'b1110, 1'b1, 4'b0010, 2'd1, 1'b1));
        tbl.push_back(v(4'b1101, 1'b1, 4'b0100, 2'd2, 1'b1));
        tbl.push_back(v(4'b1011, 1'b1, 4'b1000, 2'd3, 1'b1));
        tbl.push_back(v(4'b0111, 1'b1, 4'b0001, 2'd0, 1'b1));
        tbl.push_back(v(4'b0111, 1'b0, 4'b0001, 2'd0, 1'b1));
        tbl.push_back(v(4'b0110, 1'b0, 4'b0100, 2'd2, 1'b1));
        tbl.push_back(v(4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0));
        tbl.push_back(v(4'b0011, 1'b1, 4'b0001, 2'd0, 1'b1));
        tbl.push_back(v(4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1));
        tbl.push_back(v(4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0));
        tbl.push_back(v(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1));
        tbl.push_back(v(4'b1001, 1'b0, 4'b0001, 2'd0, 1'b1));
        tbl.push_back(v(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0));

        rst_a = 1'b1;
        rst_b = 1'b1;
        req_a = 4'b0000;
        req_b = 4'b0000;
        rr_a  = 1'b0;
        rr_b  = 1'b0;
        #12;
        chk("rst_a.gnt", 32'(gnt_a), 32'h0);
        chk("rst_a.idx", 32'(idx_a), 32'h0);
        chk("rst_a.vld", 32'(vld_a), 32'h0);
        chk("rst_b.gnt", 32'(gnt_b), 32'h0);
        chk("rst_b.idx", 32'(idx_b), 32'h0);
        chk("rst_b.vld", 32'(vld_b), 32'h0);
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(1'b0, tbl[i].req, tbl[i].rr, tbl[i].gnt, tbl[i].idx,
                  tbl[i].vld, i);
        end

        // hold limit 3: winner 3 for three edges, forced over to 0, then back
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1, 100 + i);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'b1001, 1'b0, 4'b0001, 2'd0, 1'b1, 103 + i);
        end
        drive(1'b1, 4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1, 106);
        // a lone requester keeps its grant with the counter saturated
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 110 + i);
        end

        // asynchronous reset in the middle of a grant
        drive(1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 200);
        #3;
        rst_a = 1'b1;
        #1;
        chk("arst.gnt", 32'(gnt_a), 32'h0);
        chk("arst.idx", 32'(idx_a), 32'h0);
        chk("arst.vld", 32'(vld_a), 32'h0);
        req_a = 4'b0000;
        @(negedge clk);
        rst_a = 1'b0;
        drive(1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 201);

        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(posedge clk);
        end
        #2;
        if (sb.size() != 0) begin
            n_chk++;
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
